// File: rtl/sopc_rst_seq_ctrl_pkg.sv
// Shared encodings for the SOPC reset/run sequencer: FSM states, done causes, reset levels.
package sopc_rst_seq_ctrl_pkg;

   localparam logic RST_ENABLE  = 1'b1;
   localparam logic RST_DISABLE = 1'b0;

   typedef enum logic [1:0] {
      SEQ_HOLD    = 2'b00,
      SEQ_RELEASE = 2'b01,
      SEQ_RUN     = 2'b10,
      SEQ_DONE    = 2'b11
   } seq_state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'b00,
      CAUSE_HALT    = 2'b01,
      CAUSE_TIMEOUT = 2'b10
   } done_cause_e;

endpackage

// File: rtl/sopc_rst_seq_ctrl_sat_counter.sv
// Saturating up-counter with clear, enable and terminal-count compare.
module sopc_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] term_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             at_term_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o     = cnt_q;
   assign at_term_o = (cnt_q == term_i);

endmodule

// File: rtl/sopc_rst_seq_ctrl.sv
// Multi-domain reset sequencer: hold, staggered release, supervised run with halt/timeout reporting.
module sopc_rst_seq_ctrl #(
   parameter int unsigned NUM_CH         = 2,
   parameter int unsigned HOLD_CYCLES    = 10,
   parameter int unsigned STAGGER_CYCLES = 2,
   parameter int unsigned RUN_CYCLES     = 50,
   parameter int unsigned CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sw_rst_req,
   input  logic              halt_in,
   output logic [NUM_CH-1:0] ch_rst,
   output logic              run_active,
   output logic              sim_done,
   output logic [1:0]        done_cause,
   output logic [CNT_W-1:0]  cycle_cnt
);

   import sopc_rst_seq_ctrl_pkg::*;

   localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REL_TERM  = CNT_W'((NUM_CH - 1) * STAGGER_CYCLES);
   localparam logic [CNT_W-1:0] RUN_TERM  = CNT_W'(RUN_CYCLES - 1);
   localparam bit               WDOG_EN   = (RUN_CYCLES != 0);

   seq_state_e        state_q;
   done_cause_e       cause_q;
   logic [NUM_CH-1:0] ch_rst_q, ch_rst_d;
   logic              run_active_q, sim_done_q;

   logic [CNT_W-1:0]  seq_cnt, seq_term;
   logic              seq_clr, seq_en, seq_at_term;
   logic              run_clr, run_en, run_at_term;

   // One counter times both phases; it is cleared on the HOLD->RELEASE hand-over.
   always_comb begin
      seq_clr  = sw_rst_req;
      seq_en   = 1'b0;
      seq_term = HOLD_TERM;
      run_clr  = 1'b1;
      run_en   = 1'b0;
      case (state_q)
         SEQ_HOLD: begin
            seq_en = 1'b1;
            if (seq_at_term) seq_clr = 1'b1;
         end
         SEQ_RELEASE: begin
            seq_en   = 1'b1;
            seq_term = REL_TERM;
         end
         SEQ_RUN: begin
            run_clr = sw_rst_req;
            run_en  = 1'b1;
         end
         SEQ_DONE: run_clr = sw_rst_req;
         default: ;
      endcase
   end

   sopc_sat_counter #(.CNT_W(CNT_W)) u_seq_cnt (
      .clk_i     (clk),
      .rst_i     (rst),
      .clr_i     (seq_clr),
      .en_i      (seq_en),
      .term_i    (seq_term),
      .cnt_o     (seq_cnt),
      .at_term_o (seq_at_term)
   );

   sopc_sat_counter #(.CNT_W(CNT_W)) u_run_cnt (
      .clk_i     (clk),
      .rst_i     (rst),
      .clr_i     (run_clr),
      .en_i      (run_en),
      .term_i    (RUN_TERM),
      .cnt_o     (cycle_cnt),
      .at_term_o (run_at_term)
   );

   for (genvar i = 0; i < NUM_CH; i++) begin : g_rel
      localparam logic [CNT_W-1:0] REL_AT = CNT_W'(i * STAGGER_CYCLES);
      assign ch_rst_d[i] = (seq_cnt >= REL_AT) ? RST_DISABLE : ch_rst_q[i];
   end

   always_ff @(posedge clk) begin
      if ((rst == RST_ENABLE) || sw_rst_req) begin
         state_q      <= SEQ_HOLD;
         ch_rst_q     <= '1;
         run_active_q <= 1'b0;
         sim_done_q   <= 1'b0;
         cause_q      <= CAUSE_NONE;
      end else begin
         case (state_q)
            SEQ_HOLD: begin
               if (seq_at_term) state_q <= SEQ_RELEASE;
            end
            SEQ_RELEASE: begin
               ch_rst_q <= ch_rst_d;
               if (seq_at_term) begin
                  state_q      <= SEQ_RUN;
                  run_active_q <= 1'b1;
               end
            end
            SEQ_RUN: begin
               if (halt_in) begin
                  state_q      <= SEQ_DONE;
                  run_active_q <= 1'b0;
                  sim_done_q   <= 1'b1;
                  cause_q      <= CAUSE_HALT;
               end else if (WDOG_EN && run_at_term) begin
                  state_q      <= SEQ_DONE;
                  run_active_q <= 1'b0;
                  sim_done_q   <= 1'b1;
                  cause_q      <= CAUSE_TIMEOUT;
               end
            end
            default: ;
         endcase
      end
   end

   assign ch_rst     = ch_rst_q;
   assign run_active = run_active_q;
   assign sim_done   = sim_done_q;
   assign done_cause = cause_q;

endmodule

// File: tb/tb_sopc_rst_seq_ctrl.sv
// Scoreboard bench for sopc_rst_seq_ctrl: default build plus a 4-domain, no-stagger, no-watchdog build.
module tb_sopc_rst_seq_ctrl;

   localparam int HOLD = 10;
   localparam int STAG = 2;
   localparam int RUNC = 50;
   localparam int RS   = HOLD + STAG;

   typedef struct packed {
      logic [3:0]  ch;
      logic        ra;
      logic        sd;
      logic [1:0]  dc;
      logic [15:0] cc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1, sw_rst_req = 1'b0, halt_in = 1'b0;
   logic [1:0]  ch_rst;
   logic        run_active, sim_done;
   logic [1:0]  done_cause;
   logic [15:0] cycle_cnt;

   logic        rst2 = 1'b1, sw2 = 1'b0, halt2 = 1'b0;
   logic [3:0]  ch_rst2;
   logic        run_active2, sim_done2;
   logic [1:0]  done_cause2;
   logic [15:0] cycle_cnt2;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb_q[$];

   int       m_n = 0;
   bit       m_done = 1'b0;
   int       m_cause = 0;
   int       m_cc = 0;
   int       n2 = 0;

   always #5 clk = ~clk;

   sopc_rst_seq_ctrl u_dut (
      .clk        (clk),
      .rst        (rst),
      .sw_rst_req (sw_rst_req),
      .halt_in    (halt_in),
      .ch_rst     (ch_rst),
      .run_active (run_active),
      .sim_done   (sim_done),
      .done_cause (done_cause),
      .cycle_cnt  (cycle_cnt)
   );

   sopc_rst_seq_ctrl #(
      .NUM_CH         (4),
      .HOLD_CYCLES    (10),
      .STAGGER_CYCLES (0),
      .RUN_CYCLES     (0),
      .CNT_W          (16)
   ) u_dut4 (
      .clk        (clk),
      .rst        (rst2),
      .sw_rst_req (sw2),
      .halt_in    (halt2),
      .ch_rst     (ch_rst2),
      .run_active (run_active2),
      .sim_done   (sim_done2),
      .done_cause (done_cause2),
      .cycle_cnt  (cycle_cnt2)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, act, exp);
      end
   endtask

   // Reference for the default build, derived from the edge index since the last reset.
   task automatic model1(input logic r, input logic sw, input logic h, output exp_t e);
      int eidx;
      if (r || sw) begin
         m_n = 0; m_done = 1'b0; m_cause = 0; m_cc = 0;
         e = '{ch: 4'b0011, ra: 1'b0, sd: 1'b0, dc: 2'b00, cc: 16'd0};
         return;
      end
      eidx = m_n;
      m_n++;
      if (!m_done) begin
         if (eidx >= RS) begin
            m_cc = eidx - RS;
            if (h && eidx > RS) begin
               m_done = 1'b1; m_cause = 1;
            end else if (RUNC != 0 && m_cc == RUNC) begin
               m_done = 1'b1; m_cause = 2;
            end
         end else begin
            m_cc = 0;
         end
      end
      e.ch = {2'b00, (eidx < HOLD + STAG), (eidx < HOLD)};
      e.ra = !m_done && (eidx >= RS);
      e.sd = m_done;
      e.dc = 2'(m_cause);
      e.cc = 16'(m_cc);
   endtask

   task automatic step1(input logic r, input logic sw, input logic h);
      exp_t e, x;
      rst = r; sw_rst_req = sw; halt_in = h;
      model1(r, sw, h, e);
      sb_q.push_back(e);
      @(posedge clk); #1;
      x = sb_q.pop_front();
      check_val("ch_rst", 32'(ch_rst), 32'(x.ch));
      check_val("run_active", 32'(run_active), 32'(x.ra));
      check_val("sim_done", 32'(sim_done), 32'(x.sd));
      check_val("done_cause", 32'(done_cause), 32'(x.dc));
      check_val("cycle_cnt", 32'(cycle_cnt), 32'(x.cc));
   endtask

   task automatic step2(input logic r);
      exp_t e, x;
      int eidx;
      rst2 = r;
      if (r) begin
         n2 = 0;
         e = '{ch: 4'hF, ra: 1'b0, sd: 1'b0, dc: 2'b00, cc: 16'd0};
      end else begin
         eidx = n2;
         n2++;
         e.ch = (eidx < 10) ? 4'hF : 4'h0;
         e.ra = (eidx >= 10);
         e.sd = 1'b0;
         e.dc = 2'b00;
         e.cc = (eidx >= 10) ? 16'(eidx - 10) : 16'd0;
      end
      sb_q.push_back(e);
      @(posedge clk); #1;
      x = sb_q.pop_front();
      check_val("ch_rst4", 32'(ch_rst2), 32'(x.ch));
      check_val("run_active4", 32'(run_active2), 32'(x.ra));
      check_val("sim_done4", 32'(sim_done2), 32'(x.sd));
      check_val("done_cause4", 32'(done_cause2), 32'(x.dc));
      check_val("cycle_cnt4", 32'(cycle_cnt2), 32'(x.cc));
   endtask

   initial begin
      // Plain run: release at 10/12, timeout at edge 62.
      repeat (10) step1(1'b1, 1'b0, 1'b0);
      repeat (70) step1(1'b0, 1'b0, 1'b0);

      // Halt pulse at edge 30, then hold still.
      step1(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 46; k++) step1(1'b0, 1'b0, k == 30);

      // Soft reset in RUN, then again in DONE.
      step1(1'b1, 1'b0, 1'b0);
      repeat (40) step1(1'b0, 1'b0, 1'b0);
      step1(1'b0, 1'b1, 1'b0);
      repeat (20) step1(1'b0, 1'b0, 1'b0);
      step1(1'b0, 1'b0, 1'b1);
      repeat (4) step1(1'b0, 1'b0, 1'b0);
      step1(1'b0, 1'b1, 1'b0);
      repeat (15) step1(1'b0, 1'b0, 1'b0);

      // rst mid-release, soft reset in HOLD, halt coinciding with timeout.
      step1(1'b1, 1'b0, 1'b0);
      repeat (11) step1(1'b0, 1'b0, 1'b0);
      step1(1'b1, 1'b0, 1'b0);
      repeat (5) step1(1'b0, 1'b0, 1'b0);
      step1(1'b0, 1'b1, 1'b0);
      repeat (62) step1(1'b0, 1'b0, 1'b0);
      step1(1'b0, 1'b0, 1'b1);
      repeat (3) step1(1'b0, 1'b0, 1'b0);

      // Four domains released together, watchdog disabled.
      rst = 1'b1;
      step2(1'b1);
      repeat (1011) step2(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
